// File: rtl/pet_pkg.sv
// pet_pkg: shared definitions for the virtual-pet need engine.
//   topState_e : top-level mode encoding (ALIVE / TEST / DEAD)
//   LVL_W_DEF  : default level width
//   sat_step   : +1/-1 step clamped to [0, maxLvl]; up and down together cancel
package pet_pkg;

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    TEST  = 2'd1,
    DEAD  = 2'd2
  } topState_e;

  localparam int LVL_W_DEF = 3;

  // Levels are carried as 8 bits here so one helper serves any LVL_W <= 8.
  function automatic logic [7:0] sat_step(input logic [7:0] level,
                                          input logic       up,
                                          input logic       down,
                                          input logic [7:0] maxLvl);
    logic [7:0] res;
    res = level;
    if (up && !down) begin
      if (level >= maxLvl) begin
        res = maxLvl;
      end else begin
        res = level + 8'd1;
      end
    end else if (down && !up) begin
      if (level == 8'd0) begin
        res = 8'd0;
      end else begin
        res = level - 8'd1;
      end
    end else begin
      res = level;
    end
    return res;
  endfunction

endpackage

// File: rtl/pet_needs_engine_need_channel.sv
// need_channel: one need level with its own decay timer.
//   clk, rst  : clock, synchronous active-low reset
//   tick      : prescaler strobe
//   freeze    : hold the decay timer and suppress decay (TEST / DEAD)
//   kill      : force the level to 0 (death)
//   up, down  : +1 / -1 requests this cycle (clamped, cancel when both set)
//   level     : registered level
module need_channel
  import pet_pkg::*;
#(
  parameter int LVL_W   = LVL_W_DEF,
  parameter int LVL_MAX = 5,
  parameter int PER_W   = 7,
  parameter int PERIOD  = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             freeze,
  input  logic             kill,
  input  logic             up,
  input  logic             down,
  output logic [LVL_W-1:0] level
);

  logic [PER_W-1:0] timerR;
  logic [LVL_W-1:0] levelR;
  logic [LVL_W-1:0] levelNextS;
  logic             decayS;

  // Decay fires on the tick where the timer sits at its last count.
  assign decayS = !freeze && tick && (timerR == PER_W'(PERIOD - 1));

  // Decay timer: counts ticks while running, reloads 0 on decay.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timerR <= '0;
    end else if (!freeze && tick) begin
      timerR <= decayS ? '0 : timerR + PER_W'(1);
    end else begin
      timerR <= timerR;
    end
  end

  // Next level: forced to 0 on death, otherwise a clamped step.
  always_comb begin
    levelNextS = levelR;
    if (kill) begin
      levelNextS = '0;
    end else begin
      levelNextS = LVL_W'(sat_step(8'(levelR), up, down | decayS, 8'(LVL_MAX)));
    end
  end

  // Level register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      levelR <= LVL_W'(LVL_MAX);
    end else begin
      levelR <= levelNextS;
    end
  end

  assign level = levelR;

endmodule

// File: rtl/pet_needs_engine.sv
// pet_needs_engine: need-level engine for the virtual pet.
//   clk, rst  : clock, synchronous active-low reset
//   refill    : per-need +1 pulses (ALIVE only)
//   heal      : +1 health pulse (ALIVE only)
//   test_tgl  : toggle test mode; sel_next / test_inc / test_dec act in test mode
//   levels    : packed levels, need n at n*LVL_W, health in the top field
//   critical  : per-need level < CRIT_LVL (all ones when dead)
//   test_mode, sel, dead, tick : mode, test channel select, death latch, tick strobe
// Optional macro PET_MOOD_EN adds the mood output and test channel N_NEEDS+1.
module pet_needs_engine
  import pet_pkg::*;
#(
  parameter int                     N_NEEDS      = 4,
  parameter int                     LVL_W        = LVL_W_DEF,
  parameter int                     LVL_MAX      = 5,
  parameter int                     CRIT_LVL     = 2,
  parameter int                     TICK_DIV     = 50,
  parameter int                     PER_W        = 7,
  parameter logic [N_NEEDS*PER_W-1:0] DECAY_PERIOD = {N_NEEDS{PER_W'(30)}},
  parameter int                     HARM_PERIOD  = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_NEEDS-1:0]             refill,
  input  logic                           heal,
  input  logic                           test_tgl,
  input  logic                           sel_next,
  input  logic                           test_inc,
  input  logic                           test_dec,
  output logic [(N_NEEDS+1)*LVL_W-1:0]   levels,
  output logic [N_NEEDS-1:0]             critical,
  output logic                           test_mode,
  output logic [2:0]                     sel,
  output logic                           dead,
  output logic                           tick
`ifdef PET_MOOD_EN
  ,
  output logic [LVL_W-1:0]               mood
`endif
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HARM_W = $clog2(HARM_PERIOD + 1);
`ifdef PET_MOOD_EN
  localparam logic [2:0] SEL_MAX = 3'(N_NEEDS + 1);
`else
  localparam logic [2:0] SEL_MAX = 3'(N_NEEDS);
`endif

  logic [PRE_W-1:0]  prescR;
  logic [PRE_W-1:0]  prescNextS;
  logic              tickR;
  topState_e         stateR;
  topState_e         stateNextS;
  logic [2:0]        selR;
  logic [LVL_W-1:0]  healthR;
  logic [LVL_W-1:0]  healthNextS;
  logic [HARM_W-1:0] harmTimerR;
  logic              harmS;
  logic              healthUpS;
  logic              healthDnS;
  logic              aliveS;
  logic              testS;
  logic              deadS;
  logic              enterDeadS;
  logic              killS;
  logic              anyCritS;
  logic [N_NEEDS-1:0] critS;
  logic [N_NEEDS-1:0] needUpS;
  logic [N_NEEDS-1:0] needDnS;
  logic [LVL_W-1:0]  needLvlS [N_NEEDS];

  assign aliveS   = (stateR == ALIVE);
  assign testS    = (stateR == TEST);
  assign deadS    = (stateR == DEAD);
  assign anyCritS = |critS;
  // Death kills every level on the same edge that health reaches 0.
  assign killS    = enterDeadS || deadS;

  // Prescaler wrap value.
  always_comb begin
    prescNextS = prescR + PRE_W'(1);
    if (prescR == PRE_W'(TICK_DIV - 1)) begin
      prescNextS = '0;
    end else begin
      prescNextS = prescR + PRE_W'(1);
    end
  end

  // Prescaler and tick register; tick is high while the count holds its last value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescR <= '0;
      tickR  <= 1'b0;
    end else begin
      prescR <= prescNextS;
      tickR  <= (prescNextS == PRE_W'(TICK_DIV - 1));
    end
  end

  // Per-need up/down requests: refill when alive, selected channel in test.
  always_comb begin
    needUpS = '0;
    needDnS = '0;
    for (int n = 0; n < N_NEEDS; n++) begin
      case (stateR)
        ALIVE: begin
          needUpS[n] = refill[n];
          needDnS[n] = 1'b0;
        end
        TEST: begin
          needUpS[n] = test_inc && (selR == 3'(n));
          needDnS[n] = test_dec && (selR == 3'(n));
        end
        default: begin
          needUpS[n] = 1'b0;
          needDnS[n] = 1'b0;
        end
      endcase
    end
  end

  for (genvar n = 0; n < N_NEEDS; n++) begin : gNeed
    need_channel #(
      .LVL_W   (LVL_W),
      .LVL_MAX (LVL_MAX),
      .PER_W   (PER_W),
      .PERIOD  (int'(DECAY_PERIOD[n*PER_W +: PER_W]))
    ) uNeed (
      .clk    (clk),
      .rst    (rst),
      .tick   (tickR),
      .freeze (!aliveS),
      .kill   (killS),
      .up     (needUpS[n]),
      .down   (needDnS[n]),
      .level  (needLvlS[n])
    );
  end

  // Critical flags straight from the level registers.
  always_comb begin
    critS = '0;
    for (int n = 0; n < N_NEEDS; n++) begin
      critS[n] = deadS ? 1'b1 : (needLvlS[n] < LVL_W'(CRIT_LVL));
    end
  end

  assign harmS = aliveS && anyCritS && tickR && (harmTimerR == HARM_W'(HARM_PERIOD - 1));

  // Harm timer: runs on ticks only while alive and some need is critical.
  always_ff @(posedge clk) begin
    if (!rst) begin
      harmTimerR <= '0;
    end else if (aliveS) begin
      if (!anyCritS) begin
        harmTimerR <= '0;
      end else if (tickR) begin
        harmTimerR <= harmS ? '0 : harmTimerR + HARM_W'(1);
      end else begin
        harmTimerR <= harmTimerR;
      end
    end else begin
      harmTimerR <= harmTimerR;
    end
  end

  // Health step requests and next value.
  always_comb begin
    healthUpS = 1'b0;
    healthDnS = 1'b0;
    case (stateR)
      ALIVE: begin
        healthUpS = heal;
        healthDnS = harmS;
      end
      TEST: begin
        healthUpS = test_inc && (selR == 3'(N_NEEDS));
        healthDnS = test_dec && (selR == 3'(N_NEEDS));
      end
      default: begin
        healthUpS = 1'b0;
        healthDnS = 1'b0;
      end
    endcase
    healthNextS = LVL_W'(sat_step(8'(healthR), healthUpS, healthDnS, 8'(LVL_MAX)));
    enterDeadS  = !deadS && (healthNextS == '0);
  end

  // Health register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      healthR <= LVL_W'(LVL_MAX);
    end else if (killS) begin
      healthR <= '0;
    end else begin
      healthR <= healthNextS;
    end
  end

  // Top mode next state; death outranks a simultaneous toggle.
  always_comb begin
    stateNextS = stateR;
    case (stateR)
      ALIVE: begin
        if (enterDeadS) begin
          stateNextS = DEAD;
        end else if (test_tgl) begin
          stateNextS = TEST;
        end else begin
          stateNextS = ALIVE;
        end
      end
      TEST: begin
        if (enterDeadS) begin
          stateNextS = DEAD;
        end else if (test_tgl) begin
          stateNextS = ALIVE;
        end else begin
          stateNextS = TEST;
        end
      end
      DEAD:    stateNextS = DEAD;
      default: stateNextS = DEAD;
    endcase
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateR <= ALIVE;
    end else begin
      stateR <= stateNextS;
    end
  end

  // Test channel select; kept across mode changes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      selR <= 3'd0;
    end else if (testS && sel_next) begin
      selR <= (selR == SEL_MAX) ? 3'd0 : selR + 3'd1;
    end else begin
      selR <= selR;
    end
  end

  // Pack the levels, health on top.
  always_comb begin
    levels = '0;
    for (int n = 0; n < N_NEEDS; n++) begin
      levels[n*LVL_W +: LVL_W] = needLvlS[n];
    end
    levels[N_NEEDS*LVL_W +: LVL_W] = healthR;
  end

  assign critical  = critS;
  assign test_mode = testS;
  assign sel       = selR;
  assign dead      = deadS;
  assign tick      = tickR;

`ifdef PET_MOOD_EN
  logic [LVL_W-1:0] moodR;
  logic [1:0]       moodTickR;
  logic             moodEvtS;
  logic             moodUpS;
  logic             moodDnS;
  logic             allHighS;
  logic [3:0]       critCntS;

  assign moodEvtS = aliveS && tickR && (moodTickR == 2'd3);

  // Mood inputs: every 4th alive tick, or the mood channel in test.
  always_comb begin
    critCntS = 4'd0;
    allHighS = 1'b1;
    for (int n = 0; n < N_NEEDS; n++) begin
      critCntS = critCntS + {3'd0, critS[n]};
      if (needLvlS[n] < LVL_W'(LVL_MAX - 1)) begin
        allHighS = 1'b0;
      end else begin
        allHighS = allHighS;
      end
    end
    moodUpS = 1'b0;
    moodDnS = 1'b0;
    case (stateR)
      ALIVE: begin
        moodUpS = moodEvtS && allHighS;
        moodDnS = moodEvtS && !allHighS && (critCntS >= 4'd2);
      end
      TEST: begin
        moodUpS = test_inc && (selR == 3'(N_NEEDS + 1));
        moodDnS = test_dec && (selR == 3'(N_NEEDS + 1));
      end
      default: begin
        moodUpS = 1'b0;
        moodDnS = 1'b0;
      end
    endcase
  end

  // Mood level and its tick divider.
  always_ff @(posedge clk) begin
    if (!rst) begin
      moodR     <= LVL_W'(LVL_MAX);
      moodTickR <= 2'd0;
    end else begin
      moodR     <= killS ? '0 : LVL_W'(sat_step(8'(moodR), moodUpS, moodDnS, 8'(LVL_MAX)));
      moodTickR <= (aliveS && tickR) ? moodTickR + 2'd1 : moodTickR;
    end
  end

  assign mood = moodR;
`endif

endmodule

// File: tb/tb_pet_needs_engine.sv
// Self-checking bench for pet_needs_engine: directed steps plus random pulses,
// checked every cycle against a cycle-count based model of the pet's rules.
module tb_pet_needs_engine;

  localparam int N    = 4;
  localparam int LW   = 3;
  localparam int LMAX = 5;
  localparam int CRIT = 2;
  localparam int TDIV = 4;
  localparam int PW   = 7;
  localparam int PER  = 3;
  localparam int HP   = 2;
  localparam logic [N*PW-1:0] DP = {N{7'd3}};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] refill = '0;
  logic heal = 1'b0, test_tgl = 1'b0, sel_next = 1'b0, test_inc = 1'b0, test_dec = 1'b0;
  logic [(N+1)*LW-1:0] levels;
  logic [N-1:0] critical;
  logic test_mode, dead, tick;
  logic [2:0] sel;
`ifdef PET_MOOD_EN
  logic [LW-1:0] mood;
`endif

  always #5 clk = ~clk;

  pet_needs_engine #(
    .N_NEEDS(N), .LVL_W(LW), .LVL_MAX(LMAX), .CRIT_LVL(CRIT), .TICK_DIV(TDIV),
    .PER_W(PW), .DECAY_PERIOD(DP), .HARM_PERIOD(HP)
  ) dut (
    .clk(clk), .rst(rst), .refill(refill), .heal(heal), .test_tgl(test_tgl),
    .sel_next(sel_next), .test_inc(test_inc), .test_dec(test_dec),
    .levels(levels), .critical(critical), .test_mode(test_mode), .sel(sel),
    .dead(dead), .tick(tick)
`ifdef PET_MOOD_EN
    , .mood(mood)
`endif
  );

  // Model: mode 0 alive, 1 test, 2 dead; index N is health.
  int mLvl [N+1];
  int mDec [N];
  int mMode, mSel, mCyc, mHarm;
  int total = 0;
  int bad = 0;

  function automatic int clampLvl(input int v);
    if (v < 0) return 0;
    if (v > LMAX) return LMAX;
    return v;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i <= N; i++) mLvl[i] = LMAX;
    for (int i = 0; i < N; i++) mDec[i] = 0;
    mMode = 0; mSel = 0; mCyc = 0; mHarm = 0;
  endtask

  // One clock of the pet's rules, using the inputs currently driven.
  task automatic modelStep();
    bit tk, anyCrit, harm, dcy;
    if (!rst) begin
      modelReset();
    end else begin
      tk = ((mCyc % TDIV) == TDIV - 1);
      anyCrit = 1'b0;
      for (int n = 0; n < N; n++) if (mLvl[n] < CRIT) anyCrit = 1'b1;
      if (mMode == 0) begin
        for (int n = 0; n < N; n++) begin
          dcy = 1'b0;
          if (tk) begin
            mDec[n]++;
            if (mDec[n] == PER) begin dcy = 1'b1; mDec[n] = 0; end
          end
          mLvl[n] = clampLvl(mLvl[n] + int'(refill[n]) - int'(dcy));
        end
        harm = 1'b0;
        if (!anyCrit) mHarm = 0;
        else if (tk) begin
          mHarm++;
          if (mHarm == HP) begin harm = 1'b1; mHarm = 0; end
        end
        mLvl[N] = clampLvl(mLvl[N] + int'(heal) - int'(harm));
        if (test_tgl) mMode = 1;
      end else if (mMode == 1) begin
        mLvl[mSel] = clampLvl(mLvl[mSel] + int'(test_inc) - int'(test_dec));
        if (sel_next) mSel = (mSel == N) ? 0 : mSel + 1;
        if (test_tgl) mMode = 0;
      end
      if (mMode != 2 && mLvl[N] == 0) mMode = 2;
      if (mMode == 2) for (int i = 0; i <= N; i++) mLvl[i] = 0;
      mCyc++;
    end
  endtask

  task automatic checkAll();
    logic [(N+1)*LW-1:0] eLv;
    logic [N-1:0] eCrit;
    for (int i = 0; i <= N; i++) eLv[i*LW +: LW] = LW'(mLvl[i]);
    for (int n = 0; n < N; n++) eCrit[n] = (mMode == 2) || (mLvl[n] < CRIT);
    cmp("levels", 32'(levels), 32'(eLv));
    cmp("critical", 32'(critical), 32'(eCrit));
    cmp("test_mode", 32'(test_mode), 32'(mMode == 1));
    cmp("sel", 32'(sel), 32'(mSel));
    cmp("dead", 32'(dead), 32'(mMode == 2));
    cmp("tick", 32'(tick), 32'((mCyc % TDIV) == TDIV - 1));
  endtask

  // Advance one clock: model, edge, sample 1 time unit later, clear pulses.
  task automatic cycle();
    modelStep();
    @(posedge clk);
    #1;
    refill = '0; heal = 1'b0; test_tgl = 1'b0;
    sel_next = 1'b0; test_inc = 1'b0; test_dec = 1'b0;
    checkAll();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  function automatic bit modelAnyCrit();
    for (int n = 0; n < N; n++) if (mLvl[n] < CRIT) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic [(N+1)*LW-1:0] allMax;
    logic [(N+1)*LW-1:0] afterIdle;
    int hBefore;
    int k;
    allMax    = {(N+1){3'd5}};
    afterIdle = {3'd5, 3'd4, 3'd4, 3'd4, 3'd4};

    // Reset and idle until the first decay.
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    cmp("reset_levels", 32'(levels), 32'(allMax));
    cmp("reset_dead", 32'(dead), 32'd0);
    idle(12);
    cmp("first_decay", 32'(levels), 32'(afterIdle));

    // Refill on need 0's decay cycle cancels.
    for (k = 0; k < 100 && !(((mCyc % TDIV) == TDIV - 1) && mDec[0] == PER - 1); k++) cycle();
    cmp("reach_decay_cycle", 32'(k < 100), 32'd1);
    hBefore = mLvl[0];
    refill = 4'b0001;
    cycle();
    cmp("refill_decay_cancel", 32'(levels[LW-1:0]), 32'(hBefore));
    refill = 4'b1111; cycle();
    refill = 4'b1111; cycle();
    refill = 4'b0001; cycle();
    cmp("refill_at_max", 32'(levels[LW-1:0]), 32'(LMAX));

    // Random refill/heal traffic while alive.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) refill = 4'($urandom);
      heal = ($urandom_range(0, 5) == 0);
      cycle();
    end

    // Starve: needs go critical, health is harmed, a heal on a harm cycle cancels.
    for (k = 0; k < 300 && !(mMode == 0 && modelAnyCrit() && ((mCyc % TDIV) == TDIV - 1) && mHarm == HP - 1); k++) cycle();
    cmp("reach_harm_cycle", 32'(k < 300), 32'd1);
    hBefore = mLvl[N];
    heal = 1'b1;
    cycle();
    cmp("heal_harm_cancel", 32'(levels[N*LW +: LW]), 32'(hBefore));
    for (k = 0; k < 400 && mMode != 2; k++) cycle();
    cmp("starved_dead", 32'(dead), 32'd1);
    refill = 4'b1111; heal = 1'b1; test_tgl = 1'b1;
    cycle();
    cmp("dead_levels_zero", 32'(levels), 32'd0);
    cmp("dead_critical", 32'(critical), 32'hF);
    idle(5);

    // Reset while dead.
    rst = 1'b0; cycle(); rst = 1'b1;
    cmp("rst_dead_levels", 32'(levels), 32'(allMax));
    cmp("rst_dead_flag", 32'(dead), 32'd0);

    // Test mode: select health and drain it to death.
    test_tgl = 1'b1; cycle();
    for (int i = 0; i < 4; i++) begin sel_next = 1'b1; cycle(); end
    cmp("sel_health", 32'(sel), 32'd4);
    for (int i = 0; i < 5; i++) begin test_dec = 1'b1; cycle(); end
    cmp("test_kill", 32'(dead), 32'd1);
    rst = 1'b0; cycle(); rst = 1'b1;

    // Test mode: select wrap, frozen timers, then reset from TEST.
    test_tgl = 1'b1; cycle();
    for (int i = 0; i < 5; i++) begin sel_next = 1'b1; cycle(); end
    cmp("sel_wrap", 32'(sel), 32'd0);
    idle(40);
    cmp("frozen_levels", 32'(levels), 32'(allMax));
    rst = 1'b0; cycle(); rst = 1'b1;
    cmp("rst_test_mode", 32'(test_mode), 32'd0);
    cmp("rst_test_sel", 32'(sel), 32'd0);

    // Mixed random traffic across all modes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) refill = 4'($urandom);
      heal     = ($urandom_range(0, 5) == 0);
      test_tgl = ($urandom_range(0, 30) == 0);
      sel_next = ($urandom_range(0, 3) == 0);
      test_inc = ($urandom_range(0, 3) == 0);
      test_dec = ($urandom_range(0, 2) == 0);
      if (mMode == 2 && $urandom_range(0, 20) == 0) rst = 1'b0;
      cycle();
      rst = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
